// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics command path: engine codes, idle command
// value and the byte-framer state encoding.
package gfx_pkg;
  localparam int         NUM_ENGINES = 5;
  localparam logic [7:0] IDLE_CMD    = 8'hFF;

  typedef enum logic [7:0] {
    CMD_TEST_PAT = 8'd0,
    CMD_FILL     = 8'd1,
    CMD_LINE     = 8'd2,
    CMD_BLIT     = 8'd3,
    CMD_SCROLL   = 8'd4
  } engine_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_DISCARD
  } framer_state_t;
endpackage

// File: rtl/cmd_framer_if.sv
// Byte-in / word-out handshake bundle of the command framer.
interface cmd_framer_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_stop;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_rtr;

  modport master (output rx_byte, rx_valid, rx_stop, out_rtr,
                  input  out_data, out_valid);
  modport slave  (input  rx_byte, rx_valid, rx_stop, out_rtr,
                  output out_data, out_valid);
endinterface

// File: rtl/word_fifo.sv
// Small synchronous FIFO; extra pointer MSB separates full from empty.
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the head slot, so a push on full still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cmd_framer.sv
// Frames the I2C byte stream into command / length / big-endian word packets
// and queues the words for the downstream engine.
module cmd_framer #(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         NUM_ENGINES = gfx_pkg::NUM_ENGINES,
  parameter logic [7:0] IDLE_CMD    = gfx_pkg::IDLE_CMD
) (
  input  logic         clk,
  input  logic         rst_,
  cmd_framer_if.slave  bus,
  output logic [7:0]   cmd,
  output logic         pkt_done,
  output logic         err,
  output logic         overflow
);
  import gfx_pkg::*;

  localparam logic [7:0] NUM_ENG_B = 8'(NUM_ENGINES);

  framer_state_t state;
  logic [7:0]    cnt;
  logic [7:0]    hi;
  logic          push, pop, fifo_empty, fifo_full;
  logic [15:0]   din;

  assign push          = (state == ST_LO) && bus.rx_valid;
  assign din           = {hi, bus.rx_byte};
  assign pop           = bus.out_valid && bus.out_rtr;
  assign bus.out_valid = !fifo_empty;

  word_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (bus.out_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // A byte and a STOP in the same cycle: the byte is applied first, then the
  // STOP is judged against the state that byte leads to.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state    <= ST_IDLE;
      cmd      <= IDLE_CMD;
      pkt_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_byte < NUM_ENG_B) begin
              if (bus.rx_stop) err <= 1'b1;
              else begin
                cmd   <= bus.rx_byte;
                state <= ST_LEN;
              end
            end else begin
              err   <= 1'b1;
              state <= bus.rx_stop ? ST_IDLE : ST_DISCARD;
            end
          end
        end
        ST_LEN: begin
          if (bus.rx_valid && bus.rx_byte == 8'd0) begin
            pkt_done <= 1'b1;
            cmd      <= IDLE_CMD;
            state    <= ST_IDLE;
          end else if (bus.rx_stop) begin
            err   <= 1'b1;
            cmd   <= IDLE_CMD;
            state <= ST_IDLE;
          end else if (bus.rx_valid) begin
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (bus.rx_stop) begin
            err   <= 1'b1;
            cmd   <= IDLE_CMD;
            state <= ST_IDLE;
          end else if (bus.rx_valid) begin
            state <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.rx_valid && cnt == 8'd1) begin
            pkt_done <= 1'b1;
            cmd      <= IDLE_CMD;
            state    <= ST_IDLE;
          end else if (bus.rx_stop) begin
            err   <= 1'b1;
            cmd   <= IDLE_CMD;
            state <= ST_IDLE;
          end else if (bus.rx_valid) begin
            state <= ST_HI;
          end
        end
        ST_DISCARD: begin
          if (bus.rx_stop) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LEN && bus.rx_valid) cnt <= bus.rx_byte;
    if (state == ST_HI && bus.rx_valid)  hi  <= bus.rx_byte;
    if (push)                            cnt <= cnt - 8'd1;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_)                           overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_cmd_framer.sv
// Bench for cmd_framer: directed packet scenarios plus random byte streams
// scored against a packet-level parse of the stream.
module tb_cmd_framer;
  import gfx_pkg::*;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] wq_t[$];

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] cmd;
  logic       pkt_done, err, overflow;

  cmd_framer_if bus();

  cmd_framer #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .bus      (bus.slave),
    .cmd      (cmd),
    .pkt_done (pkt_done),
    .err      (err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int  errors = 0, checks = 0;
  int  done_cnt = 0, err_cnt = 0;
  wq_t got_q;
  int  rtr_mode = 1;   // 0: hold off, 1: always ready, 2: random ready

  always @(posedge clk) begin
    #1;
    bus.out_rtr = (rtr_mode == 2) ? ($urandom_range(3) != 0) : (rtr_mode == 1);
  end

  always @(negedge clk) begin
    if (rst_ === 1'b0) begin
      if (pkt_done) done_cnt++;
      if (err) err_cnt++;
      if (bus.out_valid && bus.out_rtr) got_q.push_back(bus.out_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Packet-level parse: whole packets counted, words of truncated packets kept.
  function automatic void model(input bq_t b, output wq_t w, output int nd, output int ne);
    int i, n, len, avail, take;
    i = 0; n = b.size(); w = {}; nd = 0; ne = 0;
    while (i < n) begin
      if (int'(b[i]) >= NUM_ENGINES) begin ne++; return; end
      i++;
      if (i >= n) begin ne++; return; end
      len = int'(b[i]); i++;
      avail = (n - i) / 2;
      take = (avail < len) ? avail : len;
      for (int k = 0; k < take; k++) w.push_back({b[i+2*k], b[i+2*k+1]});
      if (avail < len) begin ne++; return; end
      i += 2 * len;
      nd++;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop);
    bus.rx_byte = b; bus.rx_valid = 1'b1; bus.rx_stop = stop;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_stop = 1'b0;
  endtask

  task automatic send_stop();
    bus.rx_stop = 1'b1;
    @(posedge clk); #1;
    bus.rx_stop = 1'b0;
  endtask

  task automatic send_bytes(input bq_t b, input bit stop_last, input int gap);
    for (int k = 0; k < b.size(); k++) begin
      send_byte(b[k], stop_last && (k == b.size() - 1));
      repeat (gap) begin @(posedge clk); #1; end
    end
    if (!stop_last) send_stop();
  endtask

  task automatic drain(input int n);
    rtr_mode = 1;
    repeat (2) begin @(posedge clk); #1; end
    for (int c = 0; c < 300; c++) begin
      if (got_q.size() >= n && !bus.out_valid) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (cmd !== IDLE_CMD) $display("FAIL reset_cmd: got %h want %h", cmd, IDLE_CMD);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    checks++; if (bus.out_data !== 16'h0) $display("FAIL reset_out_data: got %h want 0000", bus.out_data);
    checks++; if ({pkt_done, err, overflow} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {pkt_done, err, overflow});
    if ({pkt_done, err, overflow} !== 3'b000 || cmd !== IDLE_CMD || bus.out_valid !== 1'b0) errors++;
    if (bus.out_data !== 16'h0) errors++;
  endtask

  task automatic test_good_packet();
    int d0 = done_cnt, e0 = err_cnt;
    wq_t exp = '{16'h1234, 16'hABCD};
    got_q.delete(); rtr_mode = 1;
    send_byte(8'h02, 1'b0);
    checks++; if (cmd !== 8'h02) begin errors++; $display("FAIL good_cmd: got %h want 02", cmd); end
    send_byte(8'h02, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'hAB, 1'b0);
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL good_early_done: got %b want 0", pkt_done); end
    send_byte(8'hCD, 1'b0);
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL good_done: got %b want 1", pkt_done); end
    checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL good_cmd_idle: got %h want ff", cmd); end
    send_stop();
    drain(2);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL good_count: got %0d want 2", got_q.size()); end
    for (int k = 0; k < 2 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp[k]) begin errors++; $display("FAIL good_word%0d: got %h want %h", k, got_q[k], exp[k]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL good_done_cnt: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL good_err_cnt: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt, e0 = err_cnt;
    got_q.delete();
    send_byte(8'h00, 1'b0);
    checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL zero_cmd: got %h want 00", cmd); end
    send_byte(8'h00, 1'b0);
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", pkt_done); end
    checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL zero_cmd_idle: got %h want ff", cmd); end
    send_stop();
    drain(0);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero_words: got %0d want 0", got_q.size()); end
    checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL zero_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_illegal_cmd();
    int d0 = done_cnt, e0 = err_cnt;
    got_q.delete();
    send_byte(8'h07, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", err); end
    send_byte(8'h01, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL illegal_cmd: got %h want ff", cmd); end
    send_stop();
    send_bytes('{8'h01, 8'h01, 8'hBE, 8'hEF}, 1'b0, 0);
    drain(1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL illegal_count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'hBEEF) begin errors++; $display("FAIL illegal_next_word: got %h want beef", got_q[0]); end
    end
    checks++; if (err_cnt - e0 != 1 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL illegal_pulses: got err=%0d done=%0d want 1 1", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_truncated();
    int d0 = done_cnt, e0 = err_cnt;
    got_q.delete();
    send_byte(8'h03, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0); send_byte(8'h77, 1'b0);
    send_stop();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL trunc_err: got %b want 1", err); end
    checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL trunc_cmd: got %h want ff", cmd); end
    drain(1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL trunc_count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'h5566) begin errors++; $display("FAIL trunc_word: got %h want 5566", got_q[0]); end
    end
    checks++; if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
      errors++; $display("FAIL trunc_pulses: got done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_overflow();
    wq_t exp;
    logic [15:0] w;
    got_q.delete();
    rtr_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_byte(8'h01, 1'b0); send_byte(8'h06, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      w = {8'(8'hA0 + k), 8'(8'h50 + k)};
      if (k <= 4) exp.push_back(w);
      send_byte(w[15:8], 1'b0); send_byte(w[7:0], 1'b0);
      if (k == 4) begin
        checks++; if (overflow !== 1'b0 || bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL ovf_before: got ovf=%b valid=%b want 0 1", overflow, bus.out_valid);
        end
        checks++; if (bus.out_data !== exp[0]) begin errors++; $display("FAIL ovf_head: got %h want %h", bus.out_data, exp[0]); end
      end
      if (k == 5) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      end
      if (k == 6) begin
        checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b want 1", pkt_done); end
      end
    end
    send_stop();
    drain(4);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp[k]) begin errors++; $display("FAIL ovf_word%0d: got %h want %h", k, got_q[k], exp[k]); end
    end
    checks++; if (bus.out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_after: got valid=%b ovf=%b want 0 1", bus.out_valid, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    rtr_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_byte(8'h04, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || cmd !== 8'h04) begin
      errors++; $display("FAIL rstmid_pre: got valid=%b cmd=%h want 1 04", bus.out_valid, cmd);
    end
    #2 rst_ = 1'b1;
    #1;
    checks++; if (cmd !== IDLE_CMD || bus.out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got cmd=%h valid=%b ovf=%b want ff 0 0", cmd, bus.out_valid, overflow);
    end
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;
    got_q.delete(); rtr_mode = 1;
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    send_bytes('{8'h02, 8'h01, 8'hCA, 8'hFE}, 1'b1, 0);
    drain(1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'hCAFE) begin errors++; $display("FAIL rstmid_word: got %h want cafe", got_q[0]); end
    end
    checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL rstmid_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      bq_t b;
      wq_t exp;
      int nd, ne, d0, e0, npk, len, cut;
      bit sl;
      b = {};
      npk = $urandom_range(2, 1);
      for (int p = 0; p < npk; p++) begin
        b.push_back(($urandom_range(9) == 0) ? 8'($urandom_range(255, 5)) : 8'($urandom_range(4)));
        len = $urandom_range(3);
        b.push_back(8'(len));
        for (int k = 0; k < 2 * len; k++) b.push_back(8'($urandom_range(255)));
      end
      if ($urandom_range(3) == 0) begin
        cut = $urandom_range(b.size() - 1, 1);
        repeat (cut) void'(b.pop_back());
      end
      sl = 1'($urandom_range(1));
      model(b, exp, nd, ne);
      got_q.delete();
      d0 = done_cnt; e0 = err_cnt;
      rtr_mode = 2;
      send_bytes(b, sl, $urandom_range(3, 1));
      drain(exp.size());
      checks++; if (got_q.size() != exp.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d want %0d", t, got_q.size(), exp.size());
      end
      for (int k = 0; k < exp.size() && k < got_q.size(); k++) begin
        checks++; if (got_q[k] !== exp[k]) begin errors++; $display("FAIL rand%0d_word%0d: got %h want %h", t, k, got_q[k], exp[k]); end
      end
      checks++; if (done_cnt - d0 != nd || err_cnt - e0 != ne) begin
        errors++; $display("FAIL rand%0d_pulses: got done=%0d err=%0d want %0d %0d", t, done_cnt - d0, err_cnt - e0, nd, ne);
      end
      checks++; if (cmd !== IDLE_CMD || overflow !== 1'b0) begin
        errors++; $display("FAIL rand%0d_end: got cmd=%h ovf=%b want ff 0", t, cmd, overflow);
      end
    end
  endtask

  initial begin
    rst_ = 1'b1;
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; bus.rx_stop = 1'b0; bus.out_rtr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_ = 1'b0;
    @(posedge clk); #1;
    test_good_packet();
    test_zero_len();
    test_illegal_cmd();
    test_truncated();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
